// File: rtl/bram_lsu_pkg.sv
// Shared constants, FSM encoding and request-decode helpers for the BRAM load/store unit.
package bram_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD_ISSUE = 3'd1;
  localparam state_t ST_RD_WAIT  = 3'd2;
  localparam state_t ST_WR       = 3'd3;
  localparam state_t ST_RESP     = 3'd4;

  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Stores only have signed widths; loads additionally allow the unsigned forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction with sign/zero extension for loads, and sub-word merge for RMW stores.
module lsu_lane_align
  import bram_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_c,
  output logic [31:0] o_merge_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    // funct3[2] selects zero extension.
    case (i_funct3[1:0])
      2'b00:   o_load_c = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   o_load_c = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_load_c = i_word;
    endcase

    o_merge_c = i_word;
    case (i_funct3[1:0])
      2'b00: begin
        case (i_lane)
          2'd1:    o_merge_c[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_c[23:16] = i_wdata[7:0];
          2'd3:    o_merge_c[31:24] = i_wdata[7:0];
          default: o_merge_c[7:0]   = i_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (i_lane[1]) o_merge_c[31:16] = i_wdata[15:0];
        else           o_merge_c[15:0]  = i_wdata[15:0];
      end
      default: o_merge_c = i_wdata;
    endcase
  end

endmodule

// File: rtl/bram_lsu.sv
// RV32 load/store requester for one port of the data BRAM; sub-word stores are read-modify-write.
// Optional performance counters are enabled with BRAM_LSU_PERF_CNT_EN.
module bram_lsu
  import bram_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_regce,
  input  logic [31:0]       mem_dout
`ifdef BRAM_LSU_PERF_CNT_EN
  ,
  output logic [31:0]       cnt_load,
  output logic [31:0]       cnt_store,
  output logic [31:0]       cnt_err
`endif
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("bram_lsu: READ_LATENCY must be 1 or 2");
  end

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  state_t              r_state;
  logic [1:0]          r_wait_cnt;
  logic                r_we;
  logic [2:0]          r_f3;
  logic [1:0]          r_lane;
  logic [31:0]         r_wdata;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_din;
  logic                r_mem_en;
  logic                r_mem_we;
  logic                r_mem_regce;

  state_t              w_state_nxt;
  logic [1:0]          w_wait_nxt;
  logic [31:0]         w_din_nxt;
  logic [31:0]         w_rdata_nxt;
  logic                w_err_nxt;
  logic                w_accept;
  logic                w_hi_bad;
  logic                w_req_err;
  logic [31:0]         w_load_data;
  logic [31:0]         w_merge_data;

  assign w_accept  = req_valid && r_req_ready;
  assign w_hi_bad  = |(req_addr >> (ADDR_W + 2));
  assign w_req_err = !f3_legal(req_we, req_funct3) ||
                     f3_misaligned(req_funct3, req_addr[1:0]) || w_hi_bad;

  lsu_lane_align u_align (
    .i_word    (mem_dout),
    .i_lane    (r_lane),
    .i_funct3  (r_f3),
    .i_wdata   (r_wdata),
    .o_load_c  (w_load_data),
    .o_merge_c (w_merge_data)
  );

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_din_nxt   = r_mem_din;
    w_rdata_nxt = 32'd0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            w_state_nxt = ST_WR;
            w_din_nxt   = req_wdata;
          end else begin
            w_state_nxt = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: begin
        w_state_nxt = ST_RD_WAIT;
        w_wait_nxt  = 2'd0;
      end
      ST_RD_WAIT: begin
        if (r_wait_cnt == LAT_LAST) begin
          if (r_we) begin
            w_state_nxt = ST_WR;
            w_din_nxt   = w_merge_data;
          end else begin
            w_state_nxt = ST_RESP;
            w_rdata_nxt = w_load_data;
          end
        end else begin
          w_wait_nxt = r_wait_cnt + 2'd1;
        end
      end
      ST_WR:   w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 2'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_mem_din   <= 32'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_regce <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_rsp_rdata <= w_rdata_nxt;
      r_rsp_err   <= w_err_nxt;
      r_mem_din   <= w_din_nxt;
      r_mem_en    <= (w_state_nxt == ST_RD_ISSUE) || (w_state_nxt == ST_WR);
      r_mem_we    <= (w_state_nxt == ST_WR);
      r_mem_regce <= (w_state_nxt == ST_RD_ISSUE) || (w_state_nxt == ST_RD_WAIT);
    end
  end

  // Request fields held for the whole transaction.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_f3       <= 3'd0;
      r_lane     <= 2'd0;
      r_wdata    <= 32'd0;
      r_mem_addr <= '0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_f3       <= req_funct3;
      r_lane     <= req_addr[1:0];
      r_wdata    <= req_wdata;
      r_mem_addr <= req_addr[ADDR_W+1:2];
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_regce = r_mem_regce;

`ifdef BRAM_LSU_PERF_CNT_EN
  logic [31:0] r_cnt_load;
  logic [31:0] r_cnt_store;
  logic [31:0] r_cnt_err;

  // One count per completed request, classified in its response cycle.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_load  <= 32'd0;
      r_cnt_store <= 32'd0;
      r_cnt_err   <= 32'd0;
    end else if (r_state == ST_RESP) begin
      if (r_rsp_err)  r_cnt_err   <= r_cnt_err + 32'd1;
      else if (r_we)  r_cnt_store <= r_cnt_store + 32'd1;
      else            r_cnt_load  <= r_cnt_load + 32'd1;
    end
  end

  assign cnt_load  = r_cnt_load;
  assign cnt_store = r_cnt_store;
  assign cnt_err   = r_cnt_err;
`endif

endmodule

// File: tb/tb_bram_lsu.sv
// Directed bench: two bram_lsu instances (READ_LATENCY 1 and 2) share stimulus, each with its own BRAM model.
module tb_bram_lsu;
  import bram_lsu_pkg::*;

  localparam int unsigned ADDR_W = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready [2];
  logic              rsp_valid [2];
  logic              rsp_err   [2];
  logic [31:0]       rsp_rdata [2];
  logic [ADDR_W-1:0] mem_addr  [2];
  logic [31:0]       mem_din   [2];
  logic [31:0]       mem_dout  [2];
  logic              mem_en    [2];
  logic              mem_we    [2];
  logic              mem_regce [2];
`ifdef BRAM_LSU_PERF_CNT_EN
  logic [31:0]       cnt_load  [2];
  logic [31:0]       cnt_store [2];
  logic [31:0]       cnt_err   [2];
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    bram_lsu #(.ADDR_W(ADDR_W), .READ_LATENCY(gi + 1)) u_dut (
      .clka       (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready[gi]),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_rdata  (rsp_rdata[gi]),
      .rsp_err    (rsp_err[gi]),
      .mem_addr   (mem_addr[gi]),
      .mem_din    (mem_din[gi]),
      .mem_en     (mem_en[gi]),
      .mem_we     (mem_we[gi]),
      .mem_regce  (mem_regce[gi]),
      .mem_dout   (mem_dout[gi])
`ifdef BRAM_LSU_PERF_CNT_EN
      ,
      .cnt_load   (cnt_load[gi]),
      .cnt_store  (cnt_store[gi]),
      .cnt_err    (cnt_err[gi])
`endif
    );

    // Behavioural BRAM: read at issue edge, optional output register gated by regce.
    logic [31:0] mem [32768];
    logic [31:0] s1 = 32'd0;
    logic [31:0] s2 = 32'd0;
    int          en_cnt  = 0;
    int          we_cnt  = 0;
    int          rsp_cnt = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdin  = 32'd0;

    always @(posedge clk) begin
      if (mem_en[gi]) begin
        en_cnt <= en_cnt + 1;
        if (mem_we[gi]) begin
          mem[mem_addr[gi]] <= mem_din[gi];
          last_waddr        <= 32'(mem_addr[gi]);
          last_wdin         <= mem_din[gi];
        end else begin
          s1 <= mem[mem_addr[gi]];
        end
      end
      if (mem_we[gi])    we_cnt  <= we_cnt + 1;
      if (mem_regce[gi]) s2      <= s1;
      if (rsp_valid[gi]) rsp_cnt <= rsp_cnt + 1;
    end

    assign mem_dout[gi] = (gi == 0) ? s1 : s2;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          got_cyc   [2];
  logic        got_err   [2];
  logic [31:0] got_rdata [2];
  int          en_base [2], we_base [2], rsp_base [2];

  task automatic snap();
    en_base[0]  = g_dut[0].en_cnt;  en_base[1]  = g_dut[1].en_cnt;
    we_base[0]  = g_dut[0].we_cnt;  we_base[1]  = g_dut[1].we_cnt;
    rsp_base[0] = g_dut[0].rsp_cnt; rsp_base[1] = g_dut[1].rsp_cnt;
  endtask

  // Issue one request to both instances; cycle 0 is the accept cycle.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bit done [2];
    int k;
    k = 0;
    while (!(req_ready[0] && req_ready[1]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("ready_timeout", 32'd0, 32'd1);
    snap();
    done = '{1'b0, 1'b0};
    got_cyc = '{0, 0};
    got_err = '{1'b0, 1'b0};
    got_rdata = '{32'd0, 32'd0};
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (!done[d] && rsp_valid[d]) begin
          done[d] = 1'b1; got_cyc[d] = c; got_err[d] = rsp_err[d]; got_rdata[d] = rsp_rdata[d];
        end
      end
      if (done[0] && done[1]) break;
    end
    for (int d = 0; d < 2; d++)
      if (!done[d]) chk($sformatf("rsp_timeout L%0d", d + 1), 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_txn(input string tag, input logic [31:0] exp_rdata, input logic exp_err,
                           input int cyc_base, input int lat_mult, input int exp_en, input int exp_we);
    int en_now, we_now, rsp_now;
    for (int d = 0; d < 2; d++) begin
      en_now  = (d == 0) ? g_dut[0].en_cnt  : g_dut[1].en_cnt;
      we_now  = (d == 0) ? g_dut[0].we_cnt  : g_dut[1].we_cnt;
      rsp_now = (d == 0) ? g_dut[0].rsp_cnt : g_dut[1].rsp_cnt;
      chk($sformatf("%s.rdata L%0d", tag, d + 1), got_rdata[d], exp_rdata);
      chk($sformatf("%s.err L%0d", tag, d + 1), 32'(got_err[d]), 32'(exp_err));
      chk($sformatf("%s.cycle L%0d", tag, d + 1), 32'(got_cyc[d]), 32'(cyc_base + lat_mult * (d + 1)));
      chk($sformatf("%s.en_pulses L%0d", tag, d + 1), 32'(en_now - en_base[d]), 32'(exp_en));
      chk($sformatf("%s.we_pulses L%0d", tag, d + 1), 32'(we_now - we_base[d]), 32'(exp_we));
      chk($sformatf("%s.rsp_pulses L%0d", tag, d + 1), 32'(rsp_now - rsp_base[d]), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst.ready L%0d", d + 1), 32'(req_ready[d]), 32'd0);
      chk($sformatf("rst.rsp_valid L%0d", d + 1), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rst.mem_en L%0d", d + 1), 32'(mem_en[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("post_rst.ready L%0d", d + 1), 32'(req_ready[d]), 32'd1);

    // Word store then word load.
    run_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    check_txn("sw10", 32'd0, 1'b0, 2, 0, 1, 1);
    chk("sw10.waddr L1", g_dut[0].last_waddr, 32'd4);
    chk("sw10.waddr L2", g_dut[1].last_waddr, 32'd4);
    chk("sw10.wdin L2", g_dut[1].last_wdin, 32'hDEADBEEF);
    run_req(1'b0, F3_W, 32'h10, 32'd0);
    check_txn("lw10", 32'hDEADBEEF, 1'b0, 2, 1, 1, 0);

    // Sub-word loads with extension.
    run_req(1'b0, F3_B, 32'h13, 32'd0);
    check_txn("lb13", 32'hFFFFFFDE, 1'b0, 2, 1, 1, 0);
    run_req(1'b0, F3_BU, 32'h13, 32'd0);
    check_txn("lbu13", 32'h000000DE, 1'b0, 2, 1, 1, 0);
    run_req(1'b0, F3_H, 32'h10, 32'd0);
    check_txn("lh10", 32'hFFFFBEEF, 1'b0, 2, 1, 1, 0);
    run_req(1'b0, F3_HU, 32'h12, 32'd0);
    check_txn("lhu12", 32'h0000DEAD, 1'b0, 2, 1, 1, 0);

    // Byte RMW; upper wdata bits must be ignored.
    run_req(1'b1, F3_B, 32'h11, 32'hAAAAAA55);
    check_txn("sb11", 32'd0, 1'b0, 3, 1, 2, 1);
    chk("sb11.wdin L1", g_dut[0].last_wdin, 32'hDEAD55EF);
    run_req(1'b0, F3_W, 32'h10, 32'd0);
    check_txn("lw10_after_sb", 32'hDEAD55EF, 1'b0, 2, 1, 1, 0);

    // Halfword RMW in the upper lane and a positive byte.
    run_req(1'b1, F3_W, 32'h14, 32'h11223344);
    check_txn("sw14", 32'd0, 1'b0, 2, 0, 1, 1);
    run_req(1'b1, F3_H, 32'h16, 32'hBBBBCAFE);
    check_txn("sh16", 32'd0, 1'b0, 3, 1, 2, 1);
    run_req(1'b0, F3_W, 32'h14, 32'd0);
    check_txn("lw14", 32'hCAFE3344, 1'b0, 2, 1, 1, 0);
    run_req(1'b0, F3_B, 32'h14, 32'd0);
    check_txn("lb14", 32'h00000044, 1'b0, 2, 1, 1, 0);
    run_req(1'b0, F3_H, 32'h16, 32'd0);
    check_txn("lh16", 32'hFFFFCAFE, 1'b0, 2, 1, 1, 0);

    // Error cases: response in cycle 1, no BRAM activity.
    run_req(1'b0, F3_W, 32'h12, 32'd0);
    check_txn("err_lw12", 32'd0, 1'b1, 1, 0, 0, 0);
    run_req(1'b1, F3_H, 32'h13, 32'h1234);
    check_txn("err_sh13", 32'd0, 1'b1, 1, 0, 0, 0);
    run_req(1'b0, F3_W, 32'h0002_0000, 32'd0);
    check_txn("err_range", 32'd0, 1'b1, 1, 0, 0, 0);
    run_req(1'b0, 3'b011, 32'h10, 32'd0);
    check_txn("err_f3_011", 32'd0, 1'b1, 1, 0, 0, 0);
    run_req(1'b1, F3_BU, 32'h10, 32'h77);
    check_txn("err_st_f3_100", 32'd0, 1'b1, 1, 0, 0, 0);

    // Reset during RD_WAIT of an SH: the RMW write and response must vanish.
    snap();
    req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h12; req_wdata = 32'h7777; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("midrst.ready L%0d", d + 1), 32'(req_ready[d]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("midrst.ready_after L%0d", d + 1), 32'(req_ready[d]), 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst.we L1", 32'(g_dut[0].we_cnt - we_base[0]), 32'd0);
    chk("midrst.we L2", 32'(g_dut[1].we_cnt - we_base[1]), 32'd0);
    chk("midrst.rsp L1", 32'(g_dut[0].rsp_cnt - rsp_base[0]), 32'd0);
    chk("midrst.rsp L2", 32'(g_dut[1].rsp_cnt - rsp_base[1]), 32'd0);

`ifdef BRAM_LSU_PERF_CNT_EN
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("cnt0.load L%0d", d + 1), cnt_load[d], 32'd0);
      chk($sformatf("cnt0.store L%0d", d + 1), cnt_store[d], 32'd0);
      chk($sformatf("cnt0.err L%0d", d + 1), cnt_err[d], 32'd0);
    end
`endif

    // Three loads, two stores, one misaligned access.
    run_req(1'b0, F3_W, 32'h10, 32'd0);
    check_txn("lw10_after_rst", 32'hDEAD55EF, 1'b0, 2, 1, 1, 0);
    run_req(1'b0, F3_B, 32'h13, 32'd0);
    check_txn("lb13_b", 32'hFFFFFFDE, 1'b0, 2, 1, 1, 0);
    run_req(1'b0, F3_HU, 32'h12, 32'd0);
    check_txn("lhu12_b", 32'h0000DEAD, 1'b0, 2, 1, 1, 0);
    run_req(1'b1, F3_W, 32'h18, 32'h01020304);
    check_txn("sw18", 32'd0, 1'b0, 2, 0, 1, 1);
    run_req(1'b1, F3_B, 32'h1B, 32'h99);
    check_txn("sb1b", 32'd0, 1'b0, 3, 1, 2, 1);
    run_req(1'b0, F3_W, 32'h11, 32'd0);
    check_txn("err_lw11", 32'd0, 1'b1, 1, 0, 0, 0);

`ifdef BRAM_LSU_PERF_CNT_EN
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("cnt.load L%0d", d + 1), cnt_load[d], 32'd3);
      chk($sformatf("cnt.store L%0d", d + 1), cnt_store[d], 32'd2);
      chk($sformatf("cnt.err L%0d", d + 1), cnt_err[d], 32'd1);
    end
`endif

    run_req(1'b0, F3_W, 32'h18, 32'd0);
    check_txn("lw18", 32'h99020304, 1'b0, 2, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_lsu.md
Name: bram_lsu

Overview:
- Load/store requester that drives one port of the on-chip dual-port data BRAM (32-bit words, single write enable, no byte enables) on behalf of the RV32IM_Zbb core pipeline.
- Decodes RV32 load/store width from funct3, checks alignment and range, and performs sub-word stores as read-modify-write.
- Returns sign- or zero-extended load data to the core.
- Tolerates either BRAM read latency: 1 cycle (LOW_LATENCY) or 2 cycles (HIGH_PERFORMANCE).

Parameters:
- ADDR_W, 15, BRAM word-address width (32768 words).
- READ_LATENCY, 2, BRAM read latency in cycles. Legal values 1 or 2; any other value is a elaboration error.

Ports:
- clka  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  single-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_addr  out  ADDR_W  BRAM word address
- mem_din  out  32  BRAM write data
- mem_en  out  1  BRAM port enable
- mem_we  out  1  BRAM write enable
- mem_regce  out  1  BRAM output register enable
- mem_dout  in  32  BRAM read data

Behaviour:
- **Registered outputs.** All outputs are registered. Reset value of every output is 0, including req_ready.
- **State machine.** States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- **Post-reset.** req_ready rises in the first cycle after rst_n deasserts.
- **IDLE.** req_ready=1. A request is accepted when req_valid and req_ready are both high (cycle 0). The request is latched and req_ready drops the next cycle.
- **Error checks.** Any of the following sends the FSM to RESP with rsp_err=1 and no BRAM access:
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]≠0
  - any set bit in addr[31:ADDR_W+2]
  - an undefined funct3 (011, 11x; for stores, anything other than 000/001/010)
- **Addressing.** mem_addr = addr[ADDR_W+1:2]. The byte lane is addr[1:0].
- **Load.**
  - RD_ISSUE (cycle 1): mem_en=1, mem_we=0, mem_regce=1.
  - RD_WAIT: a counter waits READ_LATENCY cycles.
  - Capture mem_dout, then extract the lane and sign- or zero-extend.
  - rsp_valid in cycle 2+READ_LATENCY.
- **SW.** WR (cycle 1): mem_en=1, mem_we=1, mem_din=wdata. rsp_valid in cycle 2.
- **SB/SH.**
  - Read as for a load.
  - Merge wdata[7:0] or wdata[15:0] into the captured word at the lane; other bytes are untouched.
  - WR in cycle 2+READ_LATENCY.
  - rsp_valid in cycle 3+READ_LATENCY.
- **Enables.** mem_en/mem_we are high only in their issue cycle. mem_regce is high from RD_ISSUE through the capture cycle.
- **RESP.** rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- **Next request.** req_ready returns in the cycle after RESP. There is only one outstanding request.
- **Reset mid-operation.**
  - The FSM returns to IDLE.
  - A pending RMW write is never issued.
  - No response is produced.
  - The BRAM contents are not touched beyond writes already issued.
- **req_valid while not ready.** Ignored. The core must hold it.

Optional Feature:
- **Macro:** BRAM_LSU_PERF_CNT_EN.
- **With the macro:**
  - Adds outputs cnt_load[31:0], cnt_store[31:0] and cnt_err[31:0], all reset 0.
  - Each increments in the RESP cycle of a successful load, a successful store, or an errored request respectively.
  - The counters wrap from 0xFFFFFFFF to 0.
- **Without the macro:** the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- **Package bram_lsu_pkg:**
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state typedef
  - READ_LATENCY legality check
- **Sub-module lsu_lane_align (combinational):**
  - Load: byte/half extraction with sign/zero extension.
  - Store: merge of the sub-word into the word.
  - Reused by both the load path and the RMW path.

Test Plan:
- SW addr 0x0000_0010, data 0xDEADBEEF, then LW 0x10:
  - mem_we pulse at word address 4.
  - rsp_rdata=0xDEADBEEF at cycle 2+READ_LATENCY after accept.
  - Run with READ_LATENCY=1 and 2.
- With word 0x10 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x10 → 0xFFFFBEEF
  - LHU 0x12 → 0x0000DEAD
- SB 0x11 data 0x55, then LW 0x10:
  - 0xDEAD55EF.
  - Exactly one read and one write pulse; response at cycle 3+READ_LATENCY.
- Each of the following gives rsp_err=1, rsp_rdata=0, and mem_en never asserted:
  - LW 0x12
  - SH 0x13
  - LW 0x0002_0000 with ADDR_W=15
  - funct3=011
- Deassert rst_n during RD_WAIT of an SH:
  - No write occurs and no rsp_valid.
  - req_ready is high the first cycle after release.
- With BRAM_LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned → counters 3/2/1.
